// File: rtl/noc_vc_input_buffer.sv
// noc_vc_input_buffer: per-VC circular flit queues with independent backpressure, counts and sticky error flags.
// Optional credit return port enabled by `NOC_VC_BUF_CREDIT_EN.
module noc_vc_input_buffer #(
  parameter int CHANNELS = 2,
  parameter int DEPTH = 8,
  parameter int THRESHOLD = 6,
  parameter int FLIT_WIDTH = 64,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int AW = $clog2(DEPTH)
`ifdef NOC_VC_BUF_CREDIT_EN
  , localparam int VW = CHANNELS > 1 ? $clog2(CHANNELS) : 1
`endif
) (
  input  logic                           noc_clk,
  input  logic                           noc_rst_n,
  input  logic                           i_clear,
  input  logic [CHANNELS-1:0]            i_valid,
  input  logic [FLIT_WIDTH-1:0]          i_flit,
  output logic [CHANNELS-1:0]            o_ready,
  output logic [CHANNELS-1:0]            o_almost_full,
  output logic [CHANNELS-1:0]            o_valid,
  output logic [CHANNELS*FLIT_WIDTH-1:0] o_flit,
  input  logic [CHANNELS-1:0]            i_ready,
  output logic [CHANNELS*CW-1:0]         o_count,
  output logic [CHANNELS-1:0]            o_overflow,
  output logic                           o_protocol_err
`ifdef NOC_VC_BUF_CREDIT_EN
  ,
  output logic                           o_credit_valid,
  output logic [VW-1:0]                  o_credit_vc
`endif
);
  logic [CW-1:0] cnt [CHANNELS];
  logic [AW-1:0] wr [CHANNELS];
  logic [AW-1:0] rd [CHANNELS];
  logic [CHANNELS-1:0] full, push, pop;
  logic multi;
  // more than one bit set means the upstream sent an illegal multi-hot request
  assign multi = |(i_valid & (i_valid - CHANNELS'(1)));
  for (genvar i = 0; i < CHANNELS; i++) begin : g_vc
    logic [FLIT_WIDTH-1:0] mem [DEPTH];
    assign full[i] = cnt[i] == CW'(DEPTH);
    assign push[i] = i_valid[i] & ~multi & ~full[i];
    assign pop[i] = (cnt[i] != '0) & i_ready[i];
    assign o_ready[i] = ~full[i];
    assign o_almost_full[i] = cnt[i] >= CW'(THRESHOLD);
    assign o_valid[i] = cnt[i] != '0;
    assign o_count[i*CW +: CW] = cnt[i];
    assign o_flit[i*FLIT_WIDTH +: FLIT_WIDTH] = mem[rd[i]];
    always_ff @(posedge noc_clk)
      if (push[i] & ~i_clear) mem[wr[i]] <= i_flit;
  end
  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) begin
      for (int v = 0; v < CHANNELS; v++) begin
        wr[v] <= '0;
        rd[v] <= '0;
        cnt[v] <= '0;
      end
      o_overflow <= '0;
      o_protocol_err <= 1'b0;
    end else if (i_clear) begin
      for (int v = 0; v < CHANNELS; v++) begin
        wr[v] <= '0;
        rd[v] <= '0;
        cnt[v] <= '0;
      end
      o_overflow <= '0;
      o_protocol_err <= 1'b0;
    end else begin
      for (int v = 0; v < CHANNELS; v++) begin
        wr[v] <= wr[v] + AW'(push[v]);
        rd[v] <= rd[v] + AW'(pop[v]);
        cnt[v] <= cnt[v] + CW'(push[v]) - CW'(pop[v]);
      end
      o_overflow <= o_overflow | (i_valid & full & {CHANNELS{~multi}});
      o_protocol_err <= o_protocol_err | multi;
    end
  end
`ifdef NOC_VC_BUF_CREDIT_EN
  // a pop can be credited in its own cycle; only losers of the priority pick are parked in pend
  logic [CW-1:0] pend [CHANNELS];
  logic [CHANNELS-1:0] avail;
  logic [VW-1:0] sel;
  for (genvar i = 0; i < CHANNELS; i++) begin : g_avail
    assign avail[i] = (pend[i] != '0) | pop[i];
  end
  always_comb begin
    sel = '0;
    for (int v = CHANNELS - 1; v >= 0; v--)
      if (avail[v]) sel = VW'(v);
  end
  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) begin
      for (int v = 0; v < CHANNELS; v++) pend[v] <= '0;
      o_credit_valid <= 1'b0;
      o_credit_vc <= '0;
    end else if (i_clear) begin
      for (int v = 0; v < CHANNELS; v++) pend[v] <= '0;
      o_credit_valid <= 1'b0;
      o_credit_vc <= '0;
    end else begin
      for (int v = 0; v < CHANNELS; v++)
        pend[v] <= pend[v] + CW'(pop[v]) - CW'(|avail && sel == VW'(v));
      o_credit_valid <= |avail;
      o_credit_vc <= sel;
    end
  end
`endif
endmodule

// File: tb/tb_noc_vc_input_buffer.sv
// tb_noc_vc_input_buffer: queue-model scoreboard bench for noc_vc_input_buffer.
module tb_noc_vc_input_buffer;
  localparam int CH = 2, D = 8, TH = 6, FW = 64, CW = 4;
  logic clk = 0, rst_n = 0, clear = 0;
  logic [CH-1:0] vld = '0, rdy = '0;
  logic [FW-1:0] flit = '0;
  logic [CH-1:0] o_ready, o_almost_full, o_valid, o_overflow;
  logic [CH*FW-1:0] o_flit;
  logic [CH*CW-1:0] o_count;
  logic o_protocol_err;
`ifdef NOC_VC_BUF_CREDIT_EN
  logic o_credit_valid;
  logic [0:0] o_credit_vc;
  int pend [CH];
  bit exp_cv;
  int exp_vc;
`endif
  noc_vc_input_buffer #(.CHANNELS(CH), .DEPTH(D), .THRESHOLD(TH), .FLIT_WIDTH(FW)) dut (
    .noc_clk(clk), .noc_rst_n(rst_n), .i_clear(clear), .i_valid(vld), .i_flit(flit),
    .o_ready(o_ready), .o_almost_full(o_almost_full), .o_valid(o_valid), .o_flit(o_flit),
    .i_ready(rdy), .o_count(o_count), .o_overflow(o_overflow), .o_protocol_err(o_protocol_err)
`ifdef NOC_VC_BUF_CREDIT_EN
    , .o_credit_valid(o_credit_valid), .o_credit_vc(o_credit_vc)
`endif
  );
  always #5 clk = ~clk;
  int total = 0, bad = 0;
  logic [FW-1:0] mq [CH][$];
  bit ovf_m [CH];
  bit perr_m;
  int n;
  bit multi;
  bit popv [CH];
  bit fullb [CH];
  task automatic chk(string name, int v, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s vc%0d got=%0h exp=%0h", name, v, act, exp);
    end
  endtask
  task automatic step(logic [CH-1:0] v, logic [CH-1:0] r, logic [FW-1:0] f, logic c);
    @(posedge clk);
    #2;
    vld = v;
    rdy = r;
    flit = f;
    clear = c;
  endtask
  // monitor: compare DUT against the queue model, then advance the model with the pending inputs
  always @(negedge clk) begin
    if (!rst_n) begin
      for (int v = 0; v < CH; v++) begin
        mq[v].delete();
        ovf_m[v] = 0;
      end
      perr_m = 0;
`ifdef NOC_VC_BUF_CREDIT_EN
      for (int v = 0; v < CH; v++) pend[v] = 0;
      exp_cv = 0;
`endif
    end else begin
      for (int v = 0; v < CH; v++) begin
        n = mq[v].size();
        chk("valid", v, 64'(o_valid[v]), 64'(n > 0));
        chk("count", v, 64'(o_count[v*CW +: CW]), 64'(n));
        chk("ready", v, 64'(o_ready[v]), 64'(n < D));
        chk("afull", v, 64'(o_almost_full[v]), 64'(n >= TH));
        chk("ovf", v, 64'(o_overflow[v]), 64'(ovf_m[v]));
        if (n > 0 && rdy[v]) chk("flit", v, o_flit[v*FW +: FW], mq[v][0]);
      end
      chk("perr", 0, 64'(o_protocol_err), 64'(perr_m));
`ifdef NOC_VC_BUF_CREDIT_EN
      chk("cred_valid", 0, 64'(o_credit_valid), 64'(exp_cv));
      if (exp_cv) chk("cred_vc", 0, 64'(o_credit_vc), 64'(exp_vc));
`endif
      multi = $countones(vld) > 1;
      if (clear) begin
        for (int v = 0; v < CH; v++) begin
          mq[v].delete();
          ovf_m[v] = 0;
        end
        perr_m = 0;
`ifdef NOC_VC_BUF_CREDIT_EN
        for (int v = 0; v < CH; v++) pend[v] = 0;
        exp_cv = 0;
`endif
      end else begin
        if (multi) perr_m = 1;
        for (int v = 0; v < CH; v++) begin
          popv[v] = rdy[v] && mq[v].size() > 0;
          fullb[v] = mq[v].size() == D;
        end
        for (int v = 0; v < CH; v++) begin
          if (popv[v]) void'(mq[v].pop_front());
          if (!multi && vld[v]) begin
            if (fullb[v]) ovf_m[v] = 1;
            else mq[v].push_back(flit);
          end
        end
`ifdef NOC_VC_BUF_CREDIT_EN
        for (int v = 0; v < CH; v++) if (popv[v]) pend[v]++;
        exp_cv = 0;
        for (int v = 0; v < CH; v++)
          if (!exp_cv && pend[v] > 0) begin
            exp_cv = 1;
            exp_vc = v;
            pend[v]--;
          end
`endif
      end
    end
  end
  logic [CH-1:0] rv, rr;
  int r;
  initial begin
    repeat (3) @(posedge clk);
    #2 rst_n = 1;
    chk("rst_valid", 0, 64'(o_valid), 64'd0);
    chk("rst_ready", 0, 64'(o_ready), 64'd3);
    chk("rst_count", 0, 64'(o_count), 64'd0);
    chk("rst_err", 0, 64'({o_overflow, o_protocol_err}), 64'd0);
    for (int k = 1; k <= 9; k++) begin
      step(k <= 8 ? 2'b01 : 2'b00, 2'b00, 64'(k), 0);
      chk("fill_count", 0, 64'(o_count[CW-1:0]), 64'(k - 1));
      chk("fill_afull", 0, 64'(o_almost_full[0]), 64'(k - 1 >= TH));
      chk("fill_ready", 0, 64'(o_ready[0]), 64'(k - 1 < D));
      chk("fill_ready", 1, 64'(o_ready[1]), 64'd1);
    end
    step(2'b01, 2'b00, 64'hAA, 0);
    step(2'b00, 2'b00, 64'h0, 0);
    chk("ovf_flag", 0, 64'(o_overflow[0]), 64'd1);
    chk("ovf_count", 0, 64'(o_count[CW-1:0]), 64'd8);
    repeat (8) step(2'b00, 2'b01, 64'h0, 0);
    step(2'b00, 2'b00, 64'h0, 0);
    chk("drain_count", 0, 64'(o_count[CW-1:0]), 64'd0);
    for (int k = 0; k < 3; k++) step(2'b01, 2'b00, 64'(8'h11 + k), 0);
    step(2'b01, 2'b01, 64'h14, 0);
    step(2'b00, 2'b00, 64'h0, 0);
    chk("pushpop_count", 0, 64'(o_count[CW-1:0]), 64'd3);
    chk("pushpop_head", 0, o_flit[FW-1:0], 64'h12);
    step(2'b11, 2'b00, 64'hBB, 0);
    step(2'b00, 2'b00, 64'h0, 0);
    chk("multi_perr", 0, 64'(o_protocol_err), 64'd1);
    chk("multi_count", 0, 64'(o_count), 64'h03);
    step(2'b00, 2'b00, 64'h0, 1);
    step(2'b00, 2'b00, 64'h0, 0);
    chk("clear_count", 0, 64'(o_count), 64'd0);
    chk("clear_flags", 0, 64'({o_overflow, o_protocol_err}), 64'd0);
`ifdef NOC_VC_BUF_CREDIT_EN
    step(2'b01, 2'b00, 64'h21, 0);
    step(2'b10, 2'b00, 64'h22, 0);
    step(2'b00, 2'b11, 64'h0, 0);
    step(2'b00, 2'b00, 64'h0, 0);
    #1 chk("credit_first", 0, 64'({o_credit_valid, o_credit_vc}), 64'b10);
    step(2'b00, 2'b00, 64'h0, 0);
    #1 chk("credit_second", 1, 64'({o_credit_valid, o_credit_vc}), 64'b11);
`endif
    step(2'b01, 2'b00, 64'h31, 0);
    step(2'b10, 2'b00, 64'h32, 0);
    step(2'b00, 2'b00, 64'h0, 0);
    rst_n = 0;
    #1 chk("midrst_count", 0, 64'(o_count), 64'd0);
    chk("midrst_valid", 0, 64'(o_valid), 64'd0);
    @(posedge clk);
    #2 rst_n = 1;
    repeat (1500) begin
      r = $urandom_range(0, 19);
      rv = r == 0 ? 2'b11 : r < 13 ? (2'b01 << $urandom_range(0, 1)) : 2'b00;
      rr = 2'($urandom_range(0, 3) & $urandom_range(0, 3));
      step(rv, rr, {$urandom, $urandom}, $urandom_range(0, 79) == 0);
    end
    repeat (3) step(2'b00, 2'b00, 64'h0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
